bitserial_mac_accum: RTL



---
 rtl/bitserial_pkg.sv | 30 +++
 rtl/bs_index_counter.sv | 73 +++++++
 rtl/bitserial_mac_accum.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bitserial_pkg.sv
// Shared constants, state encoding and width helpers for the bit-serial MAC datapath.
package bitserial_pkg;

   // Default operand widths and dot-product length shared with mul_1bit-level benches
   localparam int DEF_WA = 4;
   localparam int DEF_WB = 4;
   localparam int DEF_K  = 8;

   // Accumulator control state: collecting bits, or holding a finished result
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Ceiling log2 for sizing counters and the accumulator
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Counter width that can hold 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/bs_index_counter.sv
// Nested i/j/k bit-position counter: i is innermost, then j, then k.
// Also used by the upstream operand serializer, so it knows nothing about weighting.
module bs_index_counter
   import bitserial_pkg::*;
#(
   parameter int WA = DEF_WA,
   parameter int WB = DEF_WB,
   parameter int K  = DEF_K
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_advance,
   output logic [cnt_w(WA)-1:0]  o_i,
   output logic [cnt_w(WB)-1:0]  o_j,
   output logic [cnt_w(K)-1:0]   o_k,
   output logic                  o_last
);

   localparam int IW = cnt_w(WA);
   localparam int JW = cnt_w(WB);
   localparam int KW = cnt_w(K);

   logic [IW-1:0] r_i;
   logic [JW-1:0] r_j;
   logic [KW-1:0] r_k;
   logic          w_i_max;
   logic          w_j_max;
   logic          w_k_max;

   assign w_i_max = (r_i == IW'(WA - 1));
   assign w_j_max = (r_j == JW'(WB - 1));
   assign w_k_max = (r_k == KW'(K - 1));

   // Advance the nested position on each accepted bit; reset and clear return to (0,0,0)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i <= '0;
         r_j <= '0;
         r_k <= '0;
      end else if (i_clear) begin
         r_i <= '0;
         r_j <= '0;
         r_k <= '0;
      end else if (i_advance) begin
         if (w_i_max) begin
            r_i <= '0;
            if (w_j_max) begin
               r_j <= '0;
               if (w_k_max) begin
                  r_k <= '0;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end else begin
               r_j <= r_j + JW'(1);
            end
         end else begin
            r_i <= r_i + IW'(1);
         end
      end else begin
         r_i <= r_i;
         r_j <= r_j;
         r_k <= r_k;
      end
   end

   assign o_i    = r_i;
   assign o_j    = r_j;
   assign o_k    = r_k;
   assign o_last = w_i_max && w_j_max && w_k_max;

endmodule

// File: rtl/bitserial_mac_accum.sv
// Bit-serial dot-product accumulator: weights each partial-product bit by 2^(i+j),
// optionally drops low-order positions (truncated multiply), and presents the sum of
// K products on a valid/ready output.
module bitserial_mac_accum
   import bitserial_pkg::*;
#(
   parameter int WA    = DEF_WA,
   parameter int WB    = DEF_WB,
   parameter int K     = DEF_K,
   parameter int TRUNC = 0,
   parameter int ACC_W = WA + WB + clog2(K)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             p_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);

   localparam int IW = cnt_w(WA);
   localparam int JW = cnt_w(WB);
   localparam int KW = cnt_w(K);
   localparam int PW = cnt_w(WA + WB);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_valid;
   logic             r_busy;
   logic [IW-1:0]    w_i;
   logic [JW-1:0]    w_j;
   logic [KW-1:0]    w_k;
   logic             w_last;
   logic             w_accept;
   logic [PW-1:0]    w_pos;
   logic [ACC_W-1:0] w_add;
   logic [ACC_W-1:0] w_acc_sum;
   logic             w_unused_k;

   assign w_accept  = in_valid && (r_state == ACCUM);
   assign w_pos     = PW'(w_i) + PW'(w_j);
   assign w_add     = (p_bit && (int'(w_pos) >= TRUNC)) ? (ACC_W'(1) << w_pos) : '0;
   assign w_acc_sum = r_acc + w_add;
   // k only matters through the last-position flag here
   assign w_unused_k = ^w_k;

   bs_index_counter #(
      .WA (WA),
      .WB (WB),
      .K  (K)
   ) u_idx (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (clear),
      .i_advance (w_accept),
      .o_i       (w_i),
      .o_j       (w_j),
      .o_k       (w_k),
      .o_last    (w_last)
   );

   // State register; reset and clear both return to collecting bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ACCUM;
      end else if (clear) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: leave ACCUM on the final bit, leave HOLD on the output handshake
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM: begin
            if (w_accept && w_last) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_nxt = ACCUM;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = ACCUM;
         end
      endcase
   end

   // Accumulate weighted bits, capture the finished sum, and release it on handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_out_sum   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (clear) begin
         r_acc       <= '0;
         r_out_sum   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_acc  <= w_acc_sum;
                  r_busy <= 1'b1;
                  if (w_last) begin
                     r_out_sum   <= w_acc_sum;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_out_valid <= 1'b0;
                  end
               end else begin
                  r_acc <= r_acc;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_busy      <= 1'b0;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign busy      = r_busy;

endmodule
